// File: rtl/conv_pkg.sv
// Shared widths and command-FSM encoding for the host bridge to the convolution core.
package conv_pkg;

    localparam int OP_W  = 25;
    localparam int RES_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } cmd_state_e;

endpackage

// File: rtl/conv_res_fifo.sv
// First-word fall-through result FIFO; head is read combinationally from storage.
module conv_res_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [W-1:0]     push_data_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Guarded here so a stray push at full or pop at empty can never corrupt pointers.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/conv_host_bridge.sv
// Toggle-handshake bridge between HPS PIO registers and the convolution core.
// state | meaning
// IDLE  | no command outstanding, waiting for a cmd toggle edge
// SEND  | operands presented with valid high, waiting for core ready
module conv_host_bridge
    import conv_pkg::*;
#(
    parameter int OP_W       = conv_pkg::OP_W,
    parameter int RES_W      = conv_pkg::RES_W,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_arstn,
    input  logic [OP_W-1:0]  i_cmd_x,
    input  logic [OP_W-1:0]  i_cmd_k,
    input  logic             i_cmd_toggle,
    output logic             o_cmd_ack_toggle,
    output logic             o_cmd_busy,
    output logic             o_cmd_err,
    input  logic             i_rd_toggle,
    output logic             o_rd_ack_toggle,
    output logic [RES_W-1:0] o_rd_data,
    output logic             o_rd_valid,
    output logic [CNT_W-1:0] o_fifo_count,
    output logic             o_underflow,
    input  logic             i_clr_err,
    output logic             o_conv_valid,
    output logic [OP_W-1:0]  o_conv_x,
    output logic [OP_W-1:0]  o_conv_k,
    input  logic             i_conv_ready,
    input  logic             i_conv_res_valid,
    input  logic [RES_W-1:0] i_conv_res,
    output logic             o_conv_res_ready
);

    cmd_state_e      state_q;
    logic            armed_q;
    logic            prev_cmd_q;
    logic            prev_rd_q;
    logic            conv_valid_q;
    logic [OP_W-1:0] conv_x_q;
    logic [OP_W-1:0] conv_k_q;
    logic            cmd_busy_q;
    logic            cmd_ack_q;
    logic            cmd_err_q;
    logic            cmd_err_d;
    logic            rd_ack_q;
    logic            underflow_q;
    logic            underflow_d;
    logic            cmd_edge;
    logic            rd_edge;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;

    // Edges are masked until the prev registers have sampled the live host levels once.
    assign cmd_edge = armed_q & (i_cmd_toggle != prev_cmd_q);
    assign rd_edge  = armed_q & (i_rd_toggle != prev_rd_q);
    assign fifo_pop = rd_edge & ~fifo_empty;

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            armed_q    <= 1'b0;
            prev_cmd_q <= 1'b0;
            prev_rd_q  <= 1'b0;
        end else begin
            armed_q    <= 1'b1;
            prev_cmd_q <= i_cmd_toggle;
            prev_rd_q  <= i_rd_toggle;
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q      <= ST_IDLE;
            conv_valid_q <= 1'b0;
            conv_x_q     <= '0;
            conv_k_q     <= '0;
            cmd_busy_q   <= 1'b0;
            cmd_ack_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_edge) begin
                        conv_x_q     <= i_cmd_x;
                        conv_k_q     <= i_cmd_k;
                        conv_valid_q <= 1'b1;
                        cmd_busy_q   <= 1'b1;
                        state_q      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (i_conv_ready) begin
                        conv_valid_q <= 1'b0;
                        cmd_busy_q   <= 1'b0;
                        cmd_ack_q    <= ~cmd_ack_q;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A new flag event in the same cycle as a clear must not be lost.
    always_comb begin
        cmd_err_d = cmd_err_q;
        if (i_clr_err) begin
            cmd_err_d = 1'b0;
        end
        if (cmd_edge && state_q == ST_SEND) begin
            cmd_err_d = 1'b1;
        end
        underflow_d = underflow_q;
        if (i_clr_err) begin
            underflow_d = 1'b0;
        end
        if (rd_edge && fifo_empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            cmd_err_q   <= 1'b0;
            underflow_q <= 1'b0;
            rd_ack_q    <= 1'b0;
        end else begin
            cmd_err_q   <= cmd_err_d;
            underflow_q <= underflow_d;
            if (rd_edge) begin
                rd_ack_q <= ~rd_ack_q;
            end
        end
    end

    conv_res_fifo #(
        .W     (RES_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_res_fifo (
        .clk_i       (i_clk),
        .rst_ni      (i_arstn),
        .push_i      (i_conv_res_valid),
        .push_data_i (i_conv_res),
        .pop_i       (fifo_pop),
        .head_o      (o_rd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (o_fifo_count)
    );

    assign o_conv_res_ready = ~fifo_full;
    assign o_rd_valid       = ~fifo_empty;
    assign o_conv_valid     = conv_valid_q;
    assign o_conv_x         = conv_x_q;
    assign o_conv_k         = conv_k_q;
    assign o_cmd_busy       = cmd_busy_q;
    assign o_cmd_ack_toggle = cmd_ack_q;
    assign o_cmd_err        = cmd_err_q;
    assign o_rd_ack_toggle  = rd_ack_q;
    assign o_underflow      = underflow_q;

endmodule

// File: tb/tb_conv_host_bridge.sv
// Directed bench for conv_host_bridge: command handshake, result FIFO, flags and reset.
module tb_conv_host_bridge;
    import conv_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             arstn;
    logic [OP_W-1:0]  cmd_x, cmd_k;
    logic             cmd_tog, rd_tog, clr_err;
    logic             conv_ready, res_valid;
    logic [RES_W-1:0] res;
    logic             cmd_ack, cmd_busy, cmd_err;
    logic             rd_ack, rd_valid, underflow;
    logic [RES_W-1:0] rd_data;
    logic [CW-1:0]    fifo_count;
    logic             conv_valid, res_ready;
    logic [OP_W-1:0]  conv_x, conv_k;

    int total = 0;
    int bad   = 0;
    logic rd_ack_exp = 1'b0;
    logic [1:0] drain_exp [8];

    always #10 clk = ~clk;

    conv_host_bridge #(.FIFO_DEPTH(DEPTH)) dut (
        .i_clk            (clk),
        .i_arstn          (arstn),
        .i_cmd_x          (cmd_x),
        .i_cmd_k          (cmd_k),
        .i_cmd_toggle     (cmd_tog),
        .o_cmd_ack_toggle (cmd_ack),
        .o_cmd_busy       (cmd_busy),
        .o_cmd_err        (cmd_err),
        .i_rd_toggle      (rd_tog),
        .o_rd_ack_toggle  (rd_ack),
        .o_rd_data        (rd_data),
        .o_rd_valid       (rd_valid),
        .o_fifo_count     (fifo_count),
        .o_underflow      (underflow),
        .i_clr_err        (clr_err),
        .o_conv_valid     (conv_valid),
        .o_conv_x         (conv_x),
        .o_conv_k         (conv_k),
        .i_conv_ready     (conv_ready),
        .i_conv_res_valid (res_valid),
        .i_conv_res       (res),
        .o_conv_res_ready (res_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic flip_rd();
        rd_tog     = ~rd_tog;
        rd_ack_exp = ~rd_ack_exp;
    endtask

    initial begin
        drain_exp[0] = 2'd1; drain_exp[1] = 2'd2; drain_exp[2] = 2'd3; drain_exp[3] = 2'd0;
        drain_exp[4] = 2'd1; drain_exp[5] = 2'd2; drain_exp[6] = 2'd3; drain_exp[7] = 2'd3;
        arstn = 1'b0; cmd_tog = 1'b1; rd_tog = 1'b0; clr_err = 1'b0;
        cmd_x = '0; cmd_k = '0; conv_ready = 1'b0; res_valid = 1'b0; res = '0;
        #25;
        check("rst_valid", conv_valid, 0);
        check("rst_busy", cmd_busy, 0);
        check("rst_ack", cmd_ack, 0);
        check("rst_err", cmd_err, 0);
        check("rst_count", fifo_count, 0);
        check("rst_rdvalid", rd_valid, 0);
        check("rst_rddata", rd_data, 0);
        check("rst_underflow", underflow, 0);
        tick();
        arstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("arm_no_valid", conv_valid, 0);
            check("arm_no_ack", cmd_ack, 0);
        end

        // First command with core ready.
        conv_ready = 1'b1;
        cmd_x = 25'h1ABCDEF; cmd_k = 25'h0000123; cmd_tog = 1'b0;
        tick();
        check("c1_valid", conv_valid, 1);
        check("c1_busy", cmd_busy, 1);
        check("c1_x", conv_x, 32'h1ABCDEF);
        check("c1_k", conv_k, 32'h0000123);
        tick();
        check("c1_valid_drop", conv_valid, 0);
        check("c1_ack", cmd_ack, 1);
        check("c1_busy_drop", cmd_busy, 0);

        // Stalled command, second toggle while busy.
        conv_ready = 1'b0;
        cmd_x = 25'h0055AA1; cmd_k = 25'h1000001; cmd_tog = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("c2_hold_valid", conv_valid, 1);
            check("c2_hold_x", conv_x, 32'h0055AA1);
            tick();
        end
        cmd_x = 25'h1FFFFFF; cmd_tog = 1'b0;
        tick();
        check("c2_err", cmd_err, 1);
        check("c2_valid_kept", conv_valid, 1);
        check("c2_x_kept", conv_x, 32'h0055AA1);
        check("c2_k_kept", conv_k, 32'h1000001);
        conv_ready = 1'b1;
        tick();
        check("c2_valid_drop", conv_valid, 0);
        check("c2_ack", cmd_ack, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("c2_one_ack", cmd_ack, 0);
            check("c2_no_valid", conv_valid, 0);
        end
        check("c2_err_sticky", cmd_err, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("c2_err_clr", cmd_err, 0);

        // Results 3,1,2 then three pops.
        res_valid = 1'b1; res = 2'd3;
        tick();
        check("f_cnt1", fifo_count, 1);
        check("f_rdvalid", rd_valid, 1);
        res = 2'd1;
        tick();
        res = 2'd2;
        tick();
        res_valid = 1'b0;
        check("f_cnt3", fifo_count, 3);
        check("f_head3", rd_data, 3);
        flip_rd();
        tick();
        check("f_head1", rd_data, 1);
        check("f_cnt2", fifo_count, 2);
        check("f_rdack1", rd_ack, rd_ack_exp);
        flip_rd();
        tick();
        check("f_head2", rd_data, 2);
        check("f_cnt1b", fifo_count, 1);
        flip_rd();
        tick();
        check("f_cnt0", fifo_count, 0);
        check("f_rdvalid0", rd_valid, 0);
        check("f_rdack3", rd_ack, rd_ack_exp);
        check("f_no_uflow", underflow, 0);

        // Fill to full, ninth result stalls in the core.
        res_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            res = 2'(i);
            tick();
        end
        res = 2'd3;
        check("full_cnt", fifo_count, 8);
        check("full_ready", res_ready, 0);
        tick();
        tick();
        check("full_hold_cnt", fifo_count, 8);
        check("full_head", rd_data, 0);
        flip_rd();
        tick();
        check("full_pop_cnt", fifo_count, 7);
        check("full_pop_ready", res_ready, 1);
        check("full_pop_head", rd_data, 1);
        tick();
        res_valid = 1'b0;
        check("ninth_in_cnt", fifo_count, 8);
        check("ninth_in_ready", res_ready, 0);
        for (int i = 0; i < 8; i++) begin
            check("drain_data", rd_data, drain_exp[i]);
            flip_rd();
            tick();
        end
        check("drain_cnt", fifo_count, 0);
        check("drain_rdack", rd_ack, rd_ack_exp);

        // Simultaneous push and pop at count 1.
        res_valid = 1'b1; res = 2'd2;
        tick();
        res = 2'd1;
        flip_rd();
        tick();
        res_valid = 1'b0;
        check("pp_cnt", fifo_count, 1);
        check("pp_head", rd_data, 1);
        flip_rd();
        tick();
        check("pp_cnt0", fifo_count, 0);

        // Underflow, clear, and set-wins-over-clear.
        flip_rd();
        tick();
        check("uf_flag", underflow, 1);
        check("uf_rdack", rd_ack, rd_ack_exp);
        check("uf_cnt", fifo_count, 0);
        clr_err = 1'b1;
        tick();
        check("uf_clr", underflow, 0);
        flip_rd();
        tick();
        check("uf_set_wins", underflow, 1);
        clr_err = 1'b0;
        tick();
        check("uf_sticky", underflow, 1);

        // Reset while in SEND with four results buffered.
        res_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            res = 2'(i + 1);
            tick();
        end
        res_valid = 1'b0;
        check("pre_rst_cnt", fifo_count, 4);
        conv_ready = 1'b0;
        cmd_tog = ~cmd_tog;
        tick();
        check("pre_rst_valid", conv_valid, 1);
        #3;
        arstn = 1'b0;
        #1;
        check("ar_valid", conv_valid, 0);
        check("ar_busy", cmd_busy, 0);
        check("ar_cnt", fifo_count, 0);
        check("ar_rdvalid", rd_valid, 0);
        check("ar_underflow", underflow, 0);
        check("ar_err", cmd_err, 0);
        check("ar_cmdack", cmd_ack, 0);
        check("ar_rdack", rd_ack, 0);
        check("ar_rddata", rd_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
